// File: rtl/i2c_resp_pkg.sv
// i2c_resp_pkg
//   Shared definitions for the I2C target responder: FSM state encoding,
//   R/W bit values and byte/bit-counter constants.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  localparam int BITS_PER_BYTE = 8;

  // Bit counter values: last data bit of a byte, and the 9th (ACK) clock.
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] ACK_BIT  = 4'(BITS_PER_BYTE);

endpackage

// File: rtl/i2c_bus_sync_det.sv
// i2c_bus_sync_det
//   Synchronizes the raw SCL/SDA bus values into clk_i, keeps one history
//   flop per line and decodes bus events from the synced/history pair.
// Ports:
//   clk_i, rst_i     system clock, asynchronous active-high reset
//   scl_i, sda_i     raw wired-AND bus values
//   sda_o            synchronized SDA (value at the decode point)
//   scl_rise_o       SCL rose
//   scl_fall_o       SCL fell
//   start_det_o      SDA fell while SCL stayed high
//   stop_det_o       SDA rose while SCL stayed high
module i2c_bus_sync_det #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];

  // Reset to the idle-bus level (both lines high) so that leaving reset
  // on an idle bus does not look like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign sda_o       = sda_s;
  assign scl_rise_o  =  scl_s & ~scl_hist_q;
  assign scl_fall_o  = ~scl_s &  scl_hist_q;
  // Requiring SCL high in both samples rejects simultaneous SCL/SDA changes.
  assign start_det_o = scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target: matches a 7-bit address, ACKs every address/write byte,
//   hands write bytes to local logic and fetches read bytes from it.
//   SDA is driven open-drain only; SCL is never driven or stretched.
// Ports:
//   clk_i, rst_i      system clock (>= 8x SCL), asynchronous active-high reset
//   scl_i, sda_i      resolved bus values
//   sda_oe_o          1 = pull SDA low
//   wr_data_o         last byte written by the master
//   wr_valid_o        pulse: wr_data_o updated
//   rd_req_o          pulse: a read byte was taken from rd_data_i
//   rd_data_i         byte to return; must be stable when the SCL fall that
//                     ends the preceding ACK clock is decoded
//   start_o, stop_o   pulses on (repeated) START / STOP
//   busy_o            addressed transfer in progress
//   rw_o              R/W bit of the matched transfer (1 = read)
//   nack_o            pulse: master NACKed a read byte
module i2c_slave_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       rw_o,
  output logic       nack_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_det (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;   // bits received so far in this byte
  logic [6:0] tx_q, tx_d;         // read-byte bits still to be driven
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_req_q, rd_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic [7:0] rx_byte;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    sda_oe_d   = sda_oe_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    nack_d     = 1'b0;
    rx_byte    = {shift_q, sda_s};

    if (stop_det) begin
      sda_oe_d  = 1'b0;
      stop_d    = 1'b1;
      busy_d    = 1'b0;
      rw_d      = I2C_WRITE;
      bit_cnt_d = '0;
      state_d   = ST_IDLE;
    end else if (start_det) begin
      sda_oe_d  = 1'b0;
      start_d   = 1'b1;
      bit_cnt_d = '0;
      state_d   = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: ;

        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = ACK_BIT;
              if (state_q == ST_WR_DATA) begin
                wr_data_d  = rx_byte;
                wr_valid_d = 1'b1;
                state_d    = ST_WR_ACK;
              end else if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'h00) begin
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // Counter at ACK_BIT: first fall pulls SDA low for the ACK clock.
        // Counter wrapped to 0 by the ACK rise: the next fall ends the ACK.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == ACK_BIT) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ST_ADDR_ACK && rw_q == I2C_READ) begin
              rd_req_d = 1'b1;
              tx_d     = rd_data_i[6:0];
              sda_oe_d = ~rd_data_i[7];
              state_d  = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == ACK_BIT) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (sda_s) begin
              nack_d  = 1'b1;
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == '0) begin
            rd_req_d = 1'b1;
            tx_d     = rd_data_i[6:0];
            sda_oe_d = ~rd_data_i[7];
            state_d  = ST_RD_DATA;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      sda_oe_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      sda_oe_q   <= sda_oe_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_req_o   = rd_req_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;
  assign nack_o     = nack_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder
//   Bus-level I2C master driving the responder, with a transaction-level
//   reference: an address matches iff its upper 7 bits equal 7'h22, matched
//   transfers are ACKed, written bytes reappear on wr_data_o in order and
//   read bytes are returned bit-for-bit from rd_data_i.
module tb_i2c_slave_responder;

  localparam int Q = 8;  // clk cycles per quarter of an SCL bit

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] rd_data_i = 8'h00;
  logic       scl_i, sda_i;
  logic       sda_oe_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o;
  logic [7:0] wr_data_o;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe_o;  // wired-AND bus

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe_o(sda_oe_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .rd_req_o(rd_req_o), .rd_data_i(rd_data_i), .start_o(start_o),
    .stop_o(stop_o), .busy_o(busy_o), .rw_o(rw_o), .nack_o(nack_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Event counters observed away from the active edge.
  int         start_cnt = 0, stop_cnt = 0, wr_cnt = 0, rd_cnt = 0, nack_cnt = 0, oe_cycles = 0;
  logic [7:0] wr_q[$];

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (start_o)  start_cnt++;
      if (stop_o)   stop_cnt++;
      if (rd_req_o) rd_cnt++;
      if (nack_o)   nack_cnt++;
      if (sda_oe_o) oe_cycles++;
      if (wr_valid_o) begin
        wr_cnt++;
        wr_q.push_back(wr_data_o);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [7:0] wbytes[4];
  logic [7:0] rbytes[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // One SCL clock; returns the bus SDA value seen late in the high phase.
  task automatic send_bit(input logic b, output logic got);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    got   = sda_i;
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      send_bit(tx[i], g);
      rx[i] = g;
    end
  endtask

  task automatic run_write(input logic [7:0] addr, input int n, input string tag);
    int s0, p0, w0, o0;
    logic g;
    logic [7:0] rx;
    logic [7:0] exp_q[$];
    bit match;
    match = (addr[7:1] == 7'h22);
    s0 = start_cnt; p0 = stop_cnt; w0 = wr_cnt; o0 = oe_cycles;
    wr_q.delete();
    i2c_start();
    xfer_byte(addr, rx);
    send_bit(1'b1, g);
    check({tag, " addr_ack"}, {31'd0, g}, {31'd0, ~match});
    if (match) begin
      check({tag, " busy"}, {31'd0, busy_o}, 32'd1);
      check({tag, " rw"}, {31'd0, rw_o}, 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      xfer_byte(wbytes[i], rx);
      send_bit(1'b1, g);
      check($sformatf("%s data_ack%0d", tag, i), {31'd0, g}, {31'd0, ~match});
      if (match) exp_q.push_back(wbytes[i]);
    end
    i2c_stop();
    tick(4);
    $display("write %s addr=%02h bytes=%0d match=%0d", tag, addr, n, match);
    check({tag, " starts"}, start_cnt - s0, 32'd1);
    check({tag, " stops"}, stop_cnt - p0, 32'd1);
    check({tag, " wr_valid_count"}, wr_cnt - w0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s wr_data%0d", tag, i),
            (i < wr_q.size()) ? {24'd0, wr_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
    check({tag, " busy_after_stop"}, {31'd0, busy_o}, 32'd0);
    check({tag, " oe_after_stop"}, {31'd0, sda_oe_o}, 32'd0);
    if (!match) check({tag, " oe_never"}, oe_cycles - o0, 32'd0);
  endtask

  task automatic run_read(input logic [7:0] addr, input int n, input string tag);
    int r0, k0;
    logic g;
    logic [7:0] rx;
    bit match;
    match = (addr[7:1] == 7'h22);
    r0 = rd_cnt; k0 = nack_cnt;
    rd_data_i = rbytes[0];
    i2c_start();
    xfer_byte(addr, rx);
    send_bit(1'b1, g);
    check({tag, " addr_ack"}, {31'd0, g}, {31'd0, ~match});
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'hFF, rx);
      check($sformatf("%s rd_byte%0d", tag, i), {24'd0, rx},
            {24'd0, match ? rbytes[i] : 8'hFF});
      if (i == 0 && match) check({tag, " rw"}, {31'd0, rw_o}, 32'd1);
      if (i + 1 < n) rd_data_i = rbytes[i+1];
      send_bit((i == n - 1) ? 1'b1 : 1'b0, g);
    end
    tick(2);
    check({tag, " oe_after_last"}, {31'd0, sda_oe_o}, 32'd0);
    i2c_stop();
    tick(4);
    $display("read %s addr=%02h bytes=%0d match=%0d", tag, addr, n, match);
    check({tag, " rd_req_count"}, rd_cnt - r0, match ? n : 0);
    check({tag, " nack_count"}, nack_cnt - k0, match ? 32'd1 : 32'd0);
    check({tag, " busy_after_stop"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    logic g;
    logic [7:0] rx;
    int s0, w0, p0;

    // Reset state
    tick(3);
    check("reset_outputs",
          {16'd0, sda_oe_o, wr_data_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o},
          32'd0);
    rst_i = 1'b0;
    tick(5);

    // Directed write
    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
    run_write(8'h44, 2, "write");

    // Directed read: ACK then NACK
    rbytes[0] = 8'h96; rbytes[1] = 8'h0F;
    run_read(8'h45, 2, "read");

    // Address mismatch
    wbytes[0] = 8'h11;
    run_write(8'h60, 1, "mismatch");

    // Repeated START after a partial write byte
    s0 = start_cnt; w0 = wr_cnt;
    rd_data_i = 8'h5A;
    i2c_start();
    xfer_byte(8'h44, rx);
    send_bit(1'b1, g);
    check("rstart addr1_ack", {31'd0, g}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(i[0], g);
    i2c_start();
    xfer_byte(8'h45, rx);
    send_bit(1'b1, g);
    check("rstart addr2_ack", {31'd0, g}, 32'd0);
    check("rstart rw", {31'd0, rw_o}, 32'd1);
    xfer_byte(8'hFF, rx);
    check("rstart rd_byte", {24'd0, rx}, 32'h5A);
    send_bit(1'b1, g);
    i2c_stop();
    tick(4);
    $display("rstart write4bits then read 5A");
    check("rstart starts", start_cnt - s0, 32'd2);
    check("rstart no_wr_valid", wr_cnt - w0, 32'd0);

    // Reset while bit 3 of 0x00 is being driven
    rd_data_i = 8'h00;
    i2c_start();
    xfer_byte(8'h45, rx);
    send_bit(1'b1, g);
    for (int i = 0; i < 4; i++) send_bit(1'b1, g);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2);
    check("midread oe_before_reset", {31'd0, sda_oe_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("midread oe_async", {31'd0, sda_oe_o}, 32'd0);
    check("midread outputs",
          {16'd0, sda_oe_o, wr_data_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o},
          32'd0);
    $display("reset asserted mid-read");
    tick(3);
    rst_i = 1'b0;
    scl_m = 1'b0; tick(Q);
    wbytes[0] = 8'h7E;
    run_write(8'h44, 1, "post_reset");

    // STOP after 5 bits of a write byte
    w0 = wr_cnt; p0 = stop_cnt;
    i2c_start();
    xfer_byte(8'h44, rx);
    send_bit(1'b1, g);
    for (int i = 0; i < 5; i++) send_bit(1'b1, g);
    i2c_stop();
    tick(4);
    $display("stop after 5 data bits");
    check("midstop no_wr_valid", wr_cnt - w0, 32'd0);
    check("midstop stops", stop_cnt - p0, 32'd1);
    check("midstop busy", {31'd0, busy_o}, 32'd0);
    wbytes[0] = 8'h01;
    run_write(8'h44, 1, "after_midstop");

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      logic [6:0] a7;
      int n;
      a7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h22;
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbytes[i] = 8'($urandom);
        rbytes[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) run_read({a7, 1'b1}, n, $sformatf("rand%0d", t));
      else                           run_write({a7, 1'b0}, n, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) for the i2cmb environment: the far end of the bus driven by the I2C multi-bus master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs.
- Write bytes go out to local logic through a valid pulse; read bytes are fetched from local logic through a request pulse.
- Drives SDA open-drain only; never drives SCL and does no clock stretching.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i; legal range 2..4.

Ports:
- clk_i  input  1  system clock; must be at least 8x the SCL frequency.
- rst_i  input  1  reset, asynchronous, active-high.
- scl_i  input  1  bus SCL, resolved wired-AND value.
- sda_i  input  1  bus SDA, resolved wired-AND value.
- sda_oe_o  output  1  1 = pull SDA low; 0 = release.
- wr_data_o  output  8  last byte received from the master.
- wr_valid_o  output  1  one-cycle pulse; wr_data_o is valid.
- rd_req_o  output  1  one-cycle pulse; rd_data_i is sampled this cycle.
- rd_data_i  input  8  byte to return to the master.
- start_o  output  1  one-cycle pulse on START or repeated START.
- stop_o  output  1  one-cycle pulse on STOP.
- busy_o  output  1  high from an addressed START until STOP.
- rw_o  output  1  R/W bit of the current matched transfer (1 = read).
- nack_o  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - Reset is asynchronous, so sda_oe_o drops to 0 in the same cycle rst_i rises, including mid-byte.
- Bus sampling and edge detection:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one history flop each.
  - Edges are decoded from the synced/history pair; "cycle N" below is the cycle an edge is decoded.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Each takes priority over every state.
  - If SCL and SDA change in the same cycle, the sample is not treated as START/STOP.
- Sampling/driving points:
  - Data bits are sampled on SCL rising edges.
  - sda_oe_o changes only at cycle N+1 after an SCL falling edge, or on STOP/START/reset.
- States:
  - IDLE: on START go to ADDR. start_o pulses at N+1, bit counter is cleared.
  - ADDR: shift 8 bits MSB-first.
    - Upper 7 bits == SLAVE_ADDR: latch rw_o, set busy_o, go to ADDR_ACK.
    - Otherwise go to IGNORE.
    - Address 7'h00 (general call) is never matched.
  - ADDR_ACK:
    - Assert sda_oe_o on the SCL fall after the 8th bit; release it on the next SCL fall.
    - Write: go to WR_DATA on the release.
    - Read: go to RD_DATA. On that same falling edge, rd_req_o pulses at N+1, rd_data_i is captured, and the MSB is driven (sda_oe_o = ~bit).
  - WR_DATA:
    - Shift 8 bits.
    - On the 8th rising edge (cycle N), wr_data_o is updated and wr_valid_o pulses at N+1.
    - Go to WR_ACK.
  - WR_ACK: ACK is driven exactly as in ADDR_ACK, then return to WR_DATA. Every byte is ACKed.
  - RD_DATA:
    - Drive the next bit on each SCL fall.
    - After the 8th bit, release SDA on the next fall and go to RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK): on the next SCL fall, pulse rd_req_o, capture a new byte, drive its MSB, go to RD_DATA.
    - 1 (NACK): pulse nack_o and go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START or STOP.
- STOP in any state:
  - sda_oe_o = 0 at N+1, stop_o pulses, busy_o and rw_o clear, go to IDLE.
  - A partial byte is discarded; wr_valid_o does not fire.
- Repeated START in any state: release SDA, pulse start_o, go to ADDR. busy_o stays high until re-match or STOP.
- Bit counter is 4 bits and counts 0..8. The 9th clock (ACK) is counted, then the counter wraps to 0.

Decomposition:
- Package i2c_resp_pkg: state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE), the I2C_READ/I2C_WRITE bit constants, and BITS_PER_BYTE = 8.
- Sub-module i2c_bus_sync_det: synchronizers, history flops, and decode of scl_rise/scl_fall/start_det/stop_det, with SYNC_STAGES as its parameter.

Test Plan:
- Write: START, 0x44, 0xA5, 0x3C, STOP.
  - Address ACK, then an ACK low on each 9th clock.
  - wr_valid_o pulses twice, with wr_data_o = 0xA5 then 0x3C.
  - start_o and stop_o pulse once each; busy_o low after STOP.
- Read: START, 0x45, rd_data_i = 0x96 then 0x0F, master ACK then NACK, STOP.
  - SDA bit sequence 10010110 then 00001111.
  - rd_req_o pulses twice and nack_o pulses once.
  - sda_oe_o = 0 after the second byte.
- Mismatch: START, 0x60, 0x11, STOP.
  - sda_oe_o stays 0 throughout.
  - No wr_valid_o, busy_o stays 0; only start_o and stop_o pulse.
- Repeated START: START, 0x44, 4 bits of data, rSTART, 0x45, read 0x5A with master NACK.
  - No wr_valid_o.
  - start_o pulses twice; rw_o = 1 after the re-match.
  - Byte 0x5A is returned.
- Reset mid-read: assert rst_i while bit 3 of 0x00 is being driven.
  - sda_oe_o = 0 in the same cycle; all outputs 0.
  - After release, the next START, 0x44 is ACKed normally.
- STOP mid-byte: STOP after 5 bits of a write byte.
  - No wr_valid_o; stop_o pulses; state returns to IDLE.
